// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: hazard bubbles, load-to-branch double stall, HALT drain.
// Optional stall performance counter enabled by defining STALL_PERF_CNT_EN.
module stall_flush_ctrl #(
  parameter int NB_CNT       = 2,
  parameter int DRAIN_CYCLES = 3
`ifdef STALL_PERF_CNT_EN
  , parameter int NB_PERF    = 32
`endif
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_valid,
  input  logic i_hazard,
  input  logic i_hazard_branch,
  input  logic i_branch_taken,
  input  logic i_halt,
  output logic o_pc_we,
  output logic o_ifid_we,
  output logic o_ifid_flush,
  output logic o_idex_bubble,
`ifdef STALL_PERF_CNT_EN
  output logic [NB_PERF-1:0] o_stall_count,
`endif
  output logic o_halted
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  localparam logic [NB_CNT-1:0] DRAIN_INIT = NB_CNT'(DRAIN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  function automatic logic [NB_CNT-1:0] dec_floor(input logic [NB_CNT-1:0] v);
    return (v != '0) ? v - 1'b1 : '0;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_halted      = (state_q == HALTED);
    if (i_reset) begin
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      o_halted      = 1'b0;
    end else if (i_valid) begin
      unique case (state_q)
        RUN: begin
          if (i_hazard) begin
            // Coincident branch_taken is dropped; ID re-presents it after the stall.
            o_idex_bubble = 1'b1;
            if (i_hazard_branch) begin
              cnt_d   = NB_CNT'(1);
              state_d = STALL;
            end
          end else if (i_halt) begin
            o_ifid_we    = 1'b1;
            o_ifid_flush = 1'b1;
            cnt_d        = DRAIN_INIT;
            state_d      = DRAIN;
          end else begin
            o_pc_we      = 1'b1;
            o_ifid_we    = 1'b1;
            o_ifid_flush = i_branch_taken;
          end
        end
        STALL: begin
          o_idex_bubble = 1'b1;
          cnt_d         = dec_floor(cnt_q);
          if (cnt_q <= NB_CNT'(1)) state_d = RUN;
        end
        DRAIN: begin
          o_ifid_we     = 1'b1;
          o_ifid_flush  = 1'b1;
          o_idex_bubble = 1'b1;
          cnt_d         = dec_floor(cnt_q);
          if (cnt_q == '0) state_d = HALTED;
        end
        HALTED: begin
          o_idex_bubble = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [NB_PERF-1:0] stall_cnt_q;

  function automatic logic [NB_PERF-1:0] sat_inc(input logic [NB_PERF-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only hazard-driven bubbles count; drain and halted bubbles are excluded.
  always_ff @(posedge i_clock) begin
    if (i_reset)
      stall_cnt_q <= '0;
    else if (i_valid && (state_q == RUN || state_q == STALL) && o_idex_bubble)
      stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign o_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed scoreboard bench for stall_flush_ctrl; output vector is {pc_we, ifid_we, flush, bubble, halted}.
module tb_stall_flush_ctrl;

  logic clk = 1'b0;
  logic rst, vld, haz, haz_br, br_tk, halt;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, halted;
`ifdef STALL_PERF_CNT_EN
  logic [2:0] stall_count;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [4:0] exp;
    string      tag;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  stall_flush_ctrl #(
    .NB_CNT(2),
    .DRAIN_CYCLES(3)
`ifdef STALL_PERF_CNT_EN
    , .NB_PERF(3)
`endif
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_valid        (vld),
    .i_hazard       (haz),
    .i_hazard_branch(haz_br),
    .i_branch_taken (br_tk),
    .i_halt         (halt),
    .o_pc_we        (pc_we),
    .o_ifid_we      (ifid_we),
    .o_ifid_flush   (ifid_flush),
    .o_idex_bubble  (idex_bubble),
`ifdef STALL_PERF_CNT_EN
    .o_stall_count  (stall_count),
`endif
    .o_halted       (halted)
  );

  // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
  task automatic step(input logic r, input logic v, input logic h, input logic hb,
                      input logic bt, input logic hl, input logic [4:0] exp, input string tag);
    sb_t e;
    logic [4:0] obs;
    rst = r; vld = v; haz = h; haz_br = hb; br_tk = bt; halt = hl;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    obs = {pc_we, ifid_we, ifid_flush, idex_bubble, halted};
    e = sb_q.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic chk_cnt(input logic [2:0] exp, input string tag);
    @(negedge clk);
    n_cmp++;
    assert (stall_count === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, stall_count, exp);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    rst = 1'b1; vld = 1'b1; haz = 1'b0; haz_br = 1'b0; br_tk = 1'b0; halt = 1'b0;
    @(posedge clk);
    #1;
    //     rst vld haz hb  bt  hlt  {pc,ifid,fl,bub,hlt}
    step(1, 1, 0, 0, 0, 0, 5'b00110, "reset_out");
    step(1, 0, 1, 1, 1, 1, 5'b00110, "reset_over_inputs");
    step(0, 1, 0, 0, 0, 0, 5'b11000, "run_idle");

    // Load-use single bubble
    step(0, 1, 1, 0, 0, 0, 5'b00010, "loaduse_bubble");
    step(0, 1, 0, 0, 0, 0, 5'b11000, "loaduse_resume");

    // Load-to-branch double bubble; branch_taken in STALL ignored
    step(0, 1, 1, 1, 0, 0, 5'b00010, "ldbr_bubble1");
    step(0, 1, 0, 0, 1, 0, 5'b00010, "ldbr_bubble2_bt_ignored");
    step(0, 1, 0, 0, 0, 0, 5'b11000, "ldbr_resume");

    // Hazard hides branch_taken; re-presented afterwards flushes once
    step(0, 1, 1, 0, 1, 0, 5'b00010, "haz_bt_noflush");
    step(0, 1, 0, 0, 1, 0, 5'b11100, "bt_flush");
    step(0, 1, 0, 0, 0, 0, 5'b11000, "bt_flush_once");

    // i_valid=0 freezes STALL with cnt=1
    step(0, 1, 1, 1, 0, 0, 5'b00010, "frz_enter");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1, 1, 5'b00000, "frz_hold");
    step(0, 1, 0, 0, 0, 0, 5'b00010, "frz_last_bubble");
    step(0, 1, 0, 0, 0, 0, 5'b11000, "frz_resume");

    // Reset mid-DRAIN returns to RUN
    step(0, 1, 0, 0, 0, 1, 5'b01100, "halt_exit_a");
    step(0, 1, 0, 0, 0, 0, 5'b01110, "drain_a");
    step(1, 1, 0, 0, 0, 0, 5'b00110, "reset_mid_drain");
    step(0, 1, 0, 0, 0, 0, 5'b11000, "run_after_drain_reset");

    // Halt with three drain cycles, then sticky HALTED
    step(0, 1, 0, 0, 1, 1, 5'b01100, "halt_exit");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 1, 5'b01110, "drain");
    for (int i = 0; i < 22; i++) step(0, 1, i[0], i[1], i[2], i[0], 5'b00011, "halted_hold");
    step(0, 0, 0, 0, 0, 0, 5'b00001, "halted_frozen");
    step(1, 1, 0, 0, 0, 0, 5'b00110, "halted_reset");
    step(0, 1, 0, 0, 0, 0, 5'b11000, "run_after_halt");

`ifdef STALL_PERF_CNT_EN
    step(1, 1, 0, 0, 0, 0, 5'b00110, "perf_reset");
    chk_cnt(3'd0, "perf_cleared");
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0, 5'b00010, "perf_bubble");
    haz = 1'b0;
    chk_cnt(3'd7, "perf_saturate");
    step(1, 1, 0, 0, 0, 0, 5'b00110, "perf_reset2");
    chk_cnt(3'd0, "perf_reset_clear");
`endif

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
